ahb_sram_slv: RTL and testbench
===============================

AHB_SRAM_SLV -- requirements
Module: ahb_sram_slv

Interface
REQ-001 Parameter HADDR_WIDTH, default 32: address bus width.
REQ-002 Parameter DATA_WIDTH, default 32: data bus width; only 32 is supported.
REQ-003 Parameter MEM_DEPTH, default 64: number of 32-bit words in the storage array.
REQ-004 Parameter WAIT_CYCLES, default 1, range 0..7: wait states inserted in every OKAY data phase.
REQ-005 Parameter BASE_ADDR, default 32'h40030000: word-aligned base address of the array.
REQ-006 Clock and reset: reset hresetn, asynchronous, active-low; clock hclk.
REQ-007 Port hclk, input, 1: clock.
REQ-008 Port hresetn, input, 1: reset.
REQ-009 Port hsel, input, 1: slave select from the decoder.
REQ-010 Port haddr, input, HADDR_WIDTH: transfer address.
REQ-011 Port htrans, input, 2: transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-012 Port hwrite, input, 1: 1 = write.
REQ-013 Port hsize, input, 3: transfer size.
REQ-014 Port hburst, input, 3: burst type; informational only, the master increments the address.
REQ-015 Port hwdata, input, DATA_WIDTH: write data, sampled in the data phase.
REQ-016 Port hwstrb, input, DATA_WIDTH/8: byte write strobes.
REQ-017 Port hready, input, 1: bus HREADY, i.e. HREADYIN.
REQ-018 Port hreadyout, output, 1: this slave's ready.
REQ-019 Port hrdata, output, DATA_WIDTH: read data.
REQ-020 Port hresp, output, 1: 0 = OKAY, 1 = ERROR.

Function
REQ-021 An address phase shall be accepted only when hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize shall then be registered.
REQ-022 If hsel=1, hready=1 and htrans is IDLE or BUSY, the next data phase shall be a zero-wait OKAY with no memory access.
REQ-023 An accepted transfer shall be in error if any of the following holds:
- offset (haddr - BASE_ADDR) is at or above MEM_DEPTH*4, or haddr is below BASE_ADDR;
- hsize is greater than 2;
- the address is misaligned for hsize.
REQ-024 The FSM shall have states IDLE, WAIT, ERR1 and ERR2, with these transitions:
- IDLE -> WAIT on an accepted valid transfer when WAIT_CYCLES > 0; otherwise stay in IDLE and complete in the next cycle.
- IDLE -> ERR1 on an accepted erroneous transfer.
- WAIT -> IDLE when the wait counter reaches WAIT_CYCLES.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> IDLE, or re-accept a new address phase in the same cycle per REQ-021.
REQ-025 An OKAY data phase shall drive hreadyout=0 for exactly WAIT_CYCLES cycles, then hreadyout=1 and hresp=0 for one cycle.
REQ-026 The ERROR response shall take two cycles: cycle 1 hreadyout=0 hresp=1 (ERR1), cycle 2 hreadyout=1 hresp=1 (ERR2).
REQ-027 An erroneous write shall not modify memory, and an erroneous read shall return hrdata=0.
REQ-028 A write shall commit in the final cycle of its data phase, the cycle with hreadyout=1.
- Committed bytes = hwstrb AND lane mask.
- Lane mask from hsize/haddr[1:0]: byte = 1<<a[1:0]; halfword = 3<<a[1:0]; word = 4'hF.
REQ-029 Read data shall be presented on hrdata in the final data-phase cycle only; hrdata shall be 0 in all other cycles.
REQ-030 A read immediately following a write to the same word shall return the newly written data.
REQ-031 The address phase of transfer N+1 shall be acceptable in the completing cycle of transfer N, allowing back-to-back pipelining.
REQ-032 While the slave is mid-transfer with hreadyout=0, new address-phase inputs shall be ignored because hready=0.
REQ-033 The array word index shall be offset[log2(MEM_DEPTH)+1:2].
REQ-034 The wait counter shall be 3 bits wide and shall clear on entry to WAIT.

Reset
REQ-035 Asserting hresetn low shall immediately force:
- FSM to IDLE and wait counter to 0;
- hreadyout=1, hresp=0, hrdata=0;
- every memory word to 0;
- any in-flight transfer aborted without committing its write.
REQ-036 After hresetn deasserts, the first accepted transfer shall be honoured on the next hclk edge.

Verification
REQ-037 With WAIT_CYCLES=1: NONSEQ write of 32'hA5A5_0001 to 0x40030000 with hwstrb=F, then read of the same address -> each data phase has hreadyout low 1 cycle, and the read returns 32'hA5A5_0001 with hresp=0.
REQ-038 Write to 0x40030100 (offset 256 = MEM_DEPTH*4) -> ERR1 then ERR2 (hresp=1 both cycles, hreadyout 0 then 1); a subsequent read of word 0 is unchanged.
REQ-039 Byte write of 8'h5C with hsize=0, haddr=0x40030006, hwstrb=F to a word holding 32'h0000_0000 -> reading 0x40030004 returns 32'h005C_0000.
REQ-040 WRAP-4 burst (NONSEQ, SEQ, BUSY, SEQ, SEQ) of writes 1..4 at 0x40030040 -> BUSY gets a zero-wait OKAY, and words 16..19 read back 1..4.
REQ-041 hresetn pulsed low during the WAIT of a write to 0x40030008 -> hreadyout=1 and hresp=0 immediately, and word 2 reads 0 after reset.
REQ-042 Halfword read at 0x40030001 -> two-cycle ERROR with hrdata=0.

Source files
------------

// File: rtl/ahb_sram_slv.sv
// AHB-Lite SRAM slave: a flop-based word array with configurable wait states,
// a two-cycle ERROR response for bad transfers and byte-lane masked writes.
module ahb_sram_slv #(
  parameter int          HADDR_WIDTH = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          MEM_DEPTH   = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h4003_0000
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel,
  input  logic [HADDR_WIDTH-1:0]  haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [HADDR_WIDTH-1:0] BASE      = HADDR_WIDTH'(BASE_ADDR);
  localparam logic [HADDR_WIDTH-1:0] SPAN      = HADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0]             WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             wait_cnt;
  logic                   pend;
  logic                   wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [3:0]             lane_q;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [HADDR_WIDTH-1:0] offset;
  logic                   can_accept;
  logic                   accept;
  logic                   xfer_err;
  logic [3:0]             lane_mask;
  logic                   complete;
  logic                   unused_bits;

  assign offset      = haddr - BASE;
  assign can_accept  = (state == S_IDLE) || (state == S_ERR2);
  assign accept      = can_accept && hsel && hready && htrans[1];
  assign complete    = (state == S_IDLE) && pend;
  assign hrdata      = (complete && !wr_q) ? mem[idx_q] : '0;
  assign unused_bits = ^{hburst, htrans[0], offset};

  always_comb begin
    xfer_err = 1'b0;
    if (haddr < BASE || offset >= SPAN)        xfer_err = 1'b1;
    if (hsize > 3'd2)                          xfer_err = 1'b1;
    if (hsize == 3'd1 && haddr[0])             xfer_err = 1'b1;
    if (hsize == 3'd2 && haddr[1:0] != 2'b00)  xfer_err = 1'b1;
  end

  always_comb begin
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = 4'b0011 << haddr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ERR2 is itself a completing cycle, so it may take a new address phase just like IDLE
  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        if (state == S_ERR2) begin
          hresp     = 1'b1;
          state_nxt = S_IDLE;
        end
        if (accept) begin
          if (xfer_err)             state_nxt = S_ERR1;
          else if (WAIT_CYCLES > 0) state_nxt = S_WAIT;
          else                      state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if ({1'b0, wait_cnt} + 4'd1 == WAIT_LAST) state_nxt = S_IDLE;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // pend marks a valid OKAY transfer whose data phase ends in the next IDLE cycle
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= 3'd0;
      pend     <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      lane_q   <= 4'b0000;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
      else                 wait_cnt <= 3'd0;
      if (can_accept)           pend <= accept && !xfer_err;
      else if (state == S_ERR1) pend <= 1'b0;
      if (accept) begin
        wr_q   <= hwrite;
        idx_q  <= offset[IDX_W+1:2];
        lane_q <= lane_mask;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (complete && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (hwstrb[b] && lane_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Randomized and directed bench for ahb_sram_slv, checked against a byte-level
// memory model that follows the address/size/strobe rules directly.
module tb_ahb_sram_slv;

  localparam int          WAITS = 1;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h4003_0000;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = 4'h0;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem [DEPTH];

  logic [1:0]  burst_trans [5] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
  logic [31:0] burst_off   [5] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h4C};
  logic [31:0] burst_data  [5] = '{32'd1, 32'd2, 32'd0, 32'd3, 32'd4};

  assign hready = hreadyout;

  ahb_sram_slv #(
    .HADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
    .WAIT_CYCLES(WAITS), .BASE_ADDR(BASE)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
    .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    if (a < BASE || (a - BASE) >= DEPTH * 4) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // A byte lane is written when it lies inside [addr, addr + size bytes) and its strobe is set
  task automatic model_write(input logic [31:0] a, input logic [2:0] s,
                             input logic [3:0] strb, input logic [31:0] d);
    int idx, lo, n;
    if (model_err(a, s)) return;
    idx = int'((a - BASE) >> 2);
    lo  = int'(a[1:0]);
    n   = 1 << s;
    for (int b = 0; b < 4; b++)
      if (strb[b] && b >= lo && b < lo + n) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic applyStimulus(input logic [31:0] a, input bit wr, input logic [2:0] s,
                               input logic [3:0] strb, input logic [31:0] wd);
    bit          err;
    bit          done;
    int          lows;
    logic [31:0] exp_rd;
    err  = model_err(a, s);
    done = 1'b0;
    lows = 0;
    exp_rd = (err || wr) ? 32'h0 : ref_mem[int'((a - BASE) >> 2)];
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = s; hwstrb = strb; hburst = 3'd0;
    @(posedge hclk); #1;
    htrans = 2'b00;
    hwdata = wd;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge hclk);
      if (hreadyout) done = 1'b1;
      else begin
        lows++;
        checkOutput("rdata_wait", hrdata, 32'h0);
        checkOutput("resp_wait", {31'b0, hresp}, {31'b0, err});
        @(posedge hclk); #1;
      end
    end
    checkOutput("ready_seen", {31'b0, done}, 32'd1);
    checkOutput("wait_states", lows, err ? 32'd1 : WAITS);
    checkOutput("resp", {31'b0, hresp}, {31'b0, err});
    if (!wr) checkOutput("rdata", hrdata, exp_rd);
    @(posedge hclk); #1;
    if (wr) model_write(a, s, strb, wd);
  endtask

  task automatic applyBurst();
    bit          prev_valid;
    logic [31:0] prev_addr, prev_data;
    bit          done;
    int          lows;
    prev_valid = 1'b0; prev_addr = '0; prev_data = '0;
    for (int i = 0; i <= 5; i++) begin
      hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; hwstrb = 4'hF; hburst = 3'b010;
      if (i < 5) begin haddr = BASE + burst_off[i]; htrans = burst_trans[i]; end
      else htrans = 2'b00;
      hwdata = prev_data;
      done = 1'b0;
      lows = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge hclk);
        if (hreadyout) done = 1'b1;
        else lows++;
        @(posedge hclk); #1;
      end
      checkOutput("burst_ready", {31'b0, done}, 32'd1);
      checkOutput("burst_waits", lows, prev_valid ? WAITS : 0);
      checkOutput("burst_resp", {31'b0, hresp}, 32'd0);
      if (prev_valid) model_write(prev_addr, 3'd2, 4'hF, prev_data);
      prev_valid = (i < 5) && burst_trans[i][1];
      prev_addr  = (i < 5) ? BASE + burst_off[i] : '0;
      prev_data  = (i < 5) ? burst_data[i] : '0;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    #2;
    checkOutput("reset_ready", {31'b0, hreadyout}, 32'd1);
    checkOutput("reset_resp", {31'b0, hresp}, 32'd0);
    checkOutput("reset_rdata", hrdata, 32'h0);
    @(posedge hclk); @(posedge hclk); #1;
    hresetn = 1'b1;

    applyStimulus(BASE, 1'b1, 3'd2, 4'hF, 32'hA5A5_0001);
    applyStimulus(BASE, 1'b0, 3'd2, 4'hF, 32'h0);
    applyStimulus(BASE + 32'h100, 1'b1, 3'd2, 4'hF, 32'h1234_5678);
    applyStimulus(BASE, 1'b0, 3'd2, 4'hF, 32'h0);
    applyStimulus(BASE + 32'h6, 1'b1, 3'd0, 4'hF, 32'h5C5C_5C5C);
    applyStimulus(BASE + 32'h4, 1'b0, 3'd2, 4'hF, 32'h0);
    applyBurst();
    for (int w = 0; w < 4; w++) applyStimulus(BASE + 32'h40 + 32'(4 * w), 1'b0, 3'd2, 4'hF, 32'h0);
    applyStimulus(BASE + 32'h1, 1'b0, 3'd1, 4'hF, 32'h0);

    hsel = 1'b1; haddr = BASE + 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; hwstrb = 4'hF;
    @(posedge hclk); #1;
    htrans = 2'b00;
    hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    checkOutput("rst_pre_wait", {31'b0, hreadyout}, 32'd0);
    hresetn = 1'b0;
    #1;
    checkOutput("rst_ready", {31'b0, hreadyout}, 32'd1);
    checkOutput("rst_resp", {31'b0, hresp}, 32'd0);
    checkOutput("rst_rdata", hrdata, 32'h0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    applyStimulus(BASE + 32'h8, 1'b0, 3'd2, 4'hF, 32'h0);
    applyStimulus(BASE, 1'b0, 3'd2, 4'hF, 32'h0);

    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 32'h100 + 32'($urandom_range(0, 64));
      else             a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (t % 3 == 2) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      applyStimulus(a, 1'($urandom_range(0, 1)), s, 4'($urandom_range(0, 15)), $urandom);
    end
    for (int w = 0; w < DEPTH; w += 5) applyStimulus(BASE + 32'(4 * w), 1'b0, 3'd2, 4'hF, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
